sdram_port_arbiter: RTL and testbench

SDRAM_PORT_ARBITER -- requirements
Module: sdram_port_arbiter

---
 rtl/sdram_port_arbiter.sv | 173 +++++++++++++++++
 tb/tb_sdram_port_arbiter.sv | 370 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sdram_port_arbiter.sv
// Multi-port SDRAM command arbiter: starvation/urgent/row-hit priority with round-robin
// tie-break, zero-latency grant, and in-order read-response routing through a tag FIFO.
module sdram_port_arbiter #(
    parameter int NPORTS     = 4,
    parameter int ADDR_W     = 25,
    parameter int DATA_W     = 16,
    parameter int ROW_LSB    = 10,
    parameter int MAX_WAIT   = 64,
    parameter int TAGQ_DEPTH = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NPORTS-1:0]          req_valid,
    input  logic [NPORTS-1:0]          req_write,
    input  logic [NPORTS*ADDR_W-1:0]   req_addr,
    input  logic [NPORTS*DATA_W-1:0]   req_wdata,
    input  logic [NPORTS*DATA_W/8-1:0] req_mask,
    input  logic [NPORTS-1:0]          req_urgent,
    output logic [NPORTS-1:0]          req_ready,
    output logic                       cmd_write,
    input  logic                       cmd_full,
    output logic                       cmd_isWrite,
    output logic [ADDR_W-1:0]          cmd_address,
    output logic [DATA_W/8-1:0]        cmd_writeMask,
    output logic [DATA_W-1:0]          cmd_writeData,
    input  logic                       rd_valid,
    input  logic [DATA_W-1:0]          rd_data,
    output logic [NPORTS-1:0]          rsp_valid,
    output logic [DATA_W-1:0]          rsp_data,
    output logic                       keep_open,
    output logic                       tag_err
);

    localparam int PW    = $clog2(NPORTS);
    localparam int WW    = $clog2(MAX_WAIT + 1);
    localparam int QW    = $clog2(TAGQ_DEPTH);
    localparam int MW    = DATA_W / 8;
    localparam int ROW_W = ADDR_W - ROW_LSB;

    logic [PW-1:0]     r_rr_ptr;
    logic [ROW_W-1:0]  r_open_row;
    logic              r_row_valid;
    logic [WW-1:0]     r_wait [NPORTS];
    logic [PW-1:0]     r_tagq [TAGQ_DEPTH];
    logic [QW-1:0]     r_tag_wr;
    logic [QW-1:0]     r_tag_rd;
    logic [QW:0]       r_tag_cnt;
    logic              r_tag_err;
    logic [NPORTS-1:0] r_rsp_valid;
    logic [DATA_W-1:0] r_rsp_data;

    logic [NPORTS-1:0] w_row_hit;
    logic [NPORTS-1:0] w_elig;
    logic [NPORTS-1:0] w_starve;
    logic [NPORTS-1:0] w_urgent;
    logic [NPORTS-1:0] w_hit;
    logic [NPORTS-1:0] w_class;
    logic              w_tagq_full;
    logic              w_grant_any;
    logic [PW-1:0]     w_grant_idx;
    logic [PW-1:0]     w_rr_next;
    logic              w_grant_write;
    logic [ROW_W-1:0]  w_grant_row;
    logic              w_push;
    logic              w_pop;
    logic [PW-1:0]     w_pop_tag;

    assign w_tagq_full = (r_tag_cnt == (QW+1)'(TAGQ_DEPTH));

    // NOTE: every signal written in always_comb is given a default first so no latch is inferred.
    always_comb begin
        w_row_hit = '0;
        w_elig    = '0;
        w_starve  = '0;
        for (int i = 0; i < NPORTS; i++) begin
            w_row_hit[i] = r_row_valid && (req_addr[i*ADDR_W+ROW_LSB +: ROW_W] == r_open_row);
            w_elig[i]    = req_valid[i] && (req_write[i] || !w_tagq_full) && !cmd_full && !rst;
            w_starve[i]  = w_elig[i] && (r_wait[i] >= WW'(MAX_WAIT));
        end
    end

    assign w_urgent = w_elig & req_urgent;
    assign w_hit    = w_elig & w_row_hit;
    assign w_class  = (|w_starve) ? w_starve :
                      (|w_urgent) ? w_urgent :
                      (|w_hit)    ? w_hit    : w_elig;

    // Round-robin search of the winning class, starting at rr_ptr and wrapping.
    always_comb begin
        int idx;
        idx         = 0;
        w_grant_any = 1'b0;
        w_grant_idx = '0;
        for (int k = 0; k < NPORTS; k++) begin
            idx = int'(r_rr_ptr) + k;
            if (idx >= NPORTS) idx = idx - NPORTS;
            if (!w_grant_any && w_class[idx]) begin
                w_grant_any = 1'b1;
                w_grant_idx = PW'(idx);
            end
        end
    end

    always_comb begin
        req_ready = '0;
        if (w_grant_any) req_ready[w_grant_idx] = 1'b1;
    end

    assign w_grant_write = req_write[w_grant_idx];
    assign w_grant_row   = req_addr[int'(w_grant_idx)*ADDR_W+ROW_LSB +: ROW_W];
    assign w_rr_next     = (w_grant_idx == PW'(NPORTS-1)) ? '0 : w_grant_idx + 1'b1;

    assign cmd_write     = w_grant_any;
    assign cmd_isWrite   = w_grant_any && w_grant_write;
    assign cmd_address   = w_grant_any ? req_addr[int'(w_grant_idx)*ADDR_W +: ADDR_W] : '0;
    assign cmd_writeMask = cmd_isWrite ? req_mask[int'(w_grant_idx)*MW +: MW] : '0;
    assign cmd_writeData = cmd_isWrite ? req_wdata[int'(w_grant_idx)*DATA_W +: DATA_W] : '0;

    assign keep_open = r_row_valid && |(req_valid & w_row_hit);

    assign w_push    = w_grant_any && !w_grant_write;
    assign w_pop     = rd_valid && (r_tag_cnt != '0);
    assign w_pop_tag = r_tagq[r_tag_rd];

    // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rr_ptr    <= '0;
            r_open_row  <= '0;
            r_row_valid <= 1'b0;
            for (int i = 0; i < NPORTS; i++) r_wait[i] <= '0;
            r_tag_wr    <= '0;
            r_tag_rd    <= '0;
            r_tag_cnt   <= '0;
            r_tag_err   <= 1'b0;
            r_rsp_valid <= '0;
            r_rsp_data  <= '0;
        end else begin
            if (w_grant_any) begin
                r_rr_ptr    <= w_rr_next;
                r_open_row  <= w_grant_row;
                r_row_valid <= 1'b1;
            end
            for (int i = 0; i < NPORTS; i++) begin
                if (!req_valid[i] || req_ready[i])  r_wait[i] <= '0;
                else if (r_wait[i] != WW'(MAX_WAIT)) r_wait[i] <= r_wait[i] + 1'b1;
            end
            if (w_push) r_tag_wr <= r_tag_wr + 1'b1;
            if (w_pop)  r_tag_rd <= r_tag_rd + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_tag_cnt <= r_tag_cnt + 1'b1;
                2'b01:   r_tag_cnt <= r_tag_cnt - 1'b1;
                default: r_tag_cnt <= r_tag_cnt;
            endcase
            r_rsp_valid <= '0;
            if (w_pop) begin
                r_rsp_valid[w_pop_tag] <= 1'b1;
                r_rsp_data             <= rd_data;
            end
            if (rd_valid && (r_tag_cnt == '0)) r_tag_err <= 1'b1;
        end
    end

    // NOTE: tag storage is not reset; the pointers and occupancy alone decide which entries are live.
    always_ff @(posedge clk) begin
        if (w_push) r_tagq[r_tag_wr] <= w_grant_idx;
    end

    assign rsp_valid = r_rsp_valid;
    assign rsp_data  = r_rsp_data;
    assign tag_err   = r_tag_err;

endmodule

// File: tb/tb_sdram_port_arbiter.sv
// Bench for sdram_port_arbiter: directed scenarios plus randomized traffic, all compared
// against a cycle-level behavioural model built from ints and a tag queue.
module tb_sdram_port_arbiter;

    localparam int N    = 4;
    localparam int AW   = 25;
    localparam int DW   = 16;
    localparam int MW   = DW / 8;
    localparam int RL   = 10;
    localparam int RW   = AW - RL;
    localparam int MAXW = 64;
    localparam int TQD  = 16;

    logic              clk;
    logic              rst;
    logic [N-1:0]      req_valid;
    logic [N-1:0]      req_write;
    logic [N*AW-1:0]   req_addr;
    logic [N*DW-1:0]   req_wdata;
    logic [N*MW-1:0]   req_mask;
    logic [N-1:0]      req_urgent;
    logic [N-1:0]      req_ready;
    logic              cmd_write;
    logic              cmd_full;
    logic              cmd_isWrite;
    logic [AW-1:0]     cmd_address;
    logic [MW-1:0]     cmd_writeMask;
    logic [DW-1:0]     cmd_writeData;
    logic              rd_valid;
    logic [DW-1:0]     rd_data;
    logic [N-1:0]      rsp_valid;
    logic [DW-1:0]     rsp_data;
    logic              keep_open;
    logic              tag_err;

    // Per-port request sources; each holds its request until granted.
    logic          p_valid  [N];
    logic          p_write  [N];
    logic          p_urgent [N];
    logic [AW-1:0] p_addr   [N];
    logic [DW-1:0] p_wdata  [N];
    logic [MW-1:0] p_mask   [N];

    always_comb begin
        for (int i = 0; i < N; i++) begin
            req_valid[i]             = p_valid[i];
            req_write[i]             = p_write[i];
            req_urgent[i]            = p_urgent[i];
            req_addr[i*AW +: AW]     = p_addr[i];
            req_wdata[i*DW +: DW]    = p_wdata[i];
            req_mask[i*MW +: MW]     = p_mask[i];
        end
    end

    sdram_port_arbiter #(
        .NPORTS(N), .ADDR_W(AW), .DATA_W(DW), .ROW_LSB(RL), .MAX_WAIT(MAXW), .TAGQ_DEPTH(TQD)
    ) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_write(req_write), .req_addr(req_addr),
        .req_wdata(req_wdata), .req_mask(req_mask), .req_urgent(req_urgent),
        .req_ready(req_ready), .cmd_write(cmd_write), .cmd_full(cmd_full),
        .cmd_isWrite(cmd_isWrite), .cmd_address(cmd_address),
        .cmd_writeMask(cmd_writeMask), .cmd_writeData(cmd_writeData),
        .rd_valid(rd_valid), .rd_data(rd_data),
        .rsp_valid(rsp_valid), .rsp_data(rsp_data),
        .keep_open(keep_open), .tag_err(tag_err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int            n_vec;
    int            n_err;
    bit            chk_en;
    logic [N-1:0]  obs_ready;
    logic          obs_keep;
    int            last_g;
    logic [RW-1:0] nxt_row;

    // Reference model state.
    int            m_rr;
    logic [RW-1:0] m_open_row;
    bit            m_row_valid;
    int            m_wait [N];
    int            m_tagq [$];
    bit            m_tag_err;
    logic [N-1:0]  m_rsp_valid;
    logic [DW-1:0] m_rsp_data;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s @%0t: got %0h, expected %0h", tag, $time, obs, exp);
        end
    endtask

    function automatic bit m_hit(input int p);
        return m_row_valid && (p_addr[p][AW-1:RL] == m_open_row);
    endfunction

    function automatic bit m_elig(input int p);
        return p_valid[p] && (p_write[p] || m_tagq.size() < TQD) && !cmd_full && !rst;
    endfunction

    function automatic bit m_in_class(input int p, input int c);
        case (c)
            0:       return m_wait[p] >= MAXW;
            1:       return p_urgent[p];
            2:       return m_hit(p);
            default: return 1'b1;
        endcase
    endfunction

    // Highest class first; within a class, first eligible port from the round-robin pointer.
    function automatic int m_grant();
        for (int c = 0; c < 4; c++)
            for (int k = 0; k < N; k++) begin
                int p = (m_rr + k) % N;
                if (m_elig(p) && m_in_class(p, c)) return p;
            end
        return -1;
    endfunction

    task automatic m_update(input int g);
        int t;
        if (rst) begin
            m_rr = 0; m_open_row = '0; m_row_valid = 0; m_tag_err = 0; m_rsp_valid = '0;
            for (int i = 0; i < N; i++) m_wait[i] = 0;
            m_tagq.delete();
            return;
        end
        m_rsp_valid = '0;
        if (rd_valid) begin
            if (m_tagq.size() > 0) begin
                t = m_tagq.pop_front();
                m_rsp_valid[t] = 1'b1;
                m_rsp_data     = rd_data;
            end else begin
                m_tag_err = 1;
            end
        end
        for (int i = 0; i < N; i++)
            m_wait[i] = (!p_valid[i] || i == g) ? 0 : ((m_wait[i] < MAXW) ? m_wait[i] + 1 : MAXW);
        if (g >= 0) begin
            m_rr        = (g + 1) % N;
            m_open_row  = p_addr[g][AW-1:RL];
            m_row_valid = 1;
            if (!p_write[g]) m_tagq.push_back(g);
        end
    endtask

    // One clock: compare at the falling edge, advance the model, then retire the granted request.
    task automatic step();
        int           g;
        logic [N-1:0] exp_ready;
        bit           exp_keep;
        @(negedge clk);
        g         = m_grant();
        exp_ready = '0;
        if (g >= 0) exp_ready[g] = 1'b1;
        exp_keep  = 0;
        for (int i = 0; i < N; i++) if (p_valid[i] && m_hit(i)) exp_keep = 1;
        obs_ready = req_ready;
        obs_keep  = keep_open;
        if (chk_en) begin
            check("req_ready", req_ready, exp_ready);
            check("cmd_write", cmd_write, g >= 0);
            if (g >= 0) begin
                check("cmd_isWrite", cmd_isWrite, p_write[g]);
                check("cmd_address", cmd_address, p_addr[g]);
                check("cmd_writeMask", cmd_writeMask, p_write[g] ? p_mask[g] : '0);
                check("cmd_writeData", cmd_writeData, p_write[g] ? p_wdata[g] : '0);
            end
            check("keep_open", keep_open, exp_keep);
            check("rsp_valid", rsp_valid, m_rsp_valid);
            if (m_rsp_valid != '0) check("rsp_data", rsp_data, m_rsp_data);
            check("tag_err", tag_err, m_tag_err);
        end
        m_update(g);
        @(posedge clk);
        #1;
        if (g >= 0) p_valid[g] = 1'b0;
        rd_valid = 1'b0;
        last_g   = g;
    endtask

    task automatic raise(input int p, input bit wr, input logic [RW-1:0] row);
        p_valid[p]  = 1'b1;
        p_write[p]  = wr;
        p_addr[p]   = {row, RL'($urandom)};
        p_wdata[p]  = DW'($urandom);
        p_mask[p]   = MW'($urandom);
        p_urgent[p] = 1'b0;
    endtask

    task automatic clear_all();
        for (int i = 0; i < N; i++) begin
            p_valid[i]  = 1'b0;
            p_urgent[i] = 1'b0;
        end
    endtask

    function automatic logic [RW-1:0] pick_row();
        case ($urandom_range(0, 3))
            0:       return 15'h1234;
            1:       return 15'h1235;
            2:       return 15'h0777;
            default: return 15'h2000;
        endcase
    endfunction

    initial begin
        n_vec = 0; n_err = 0; chk_en = 0; last_g = -1; nxt_row = 15'h0100;
        rst = 1'b1; cmd_full = 1'b0; rd_valid = 1'b0; rd_data = '0;
        for (int i = 0; i < N; i++) begin
            p_valid[i] = 0; p_write[i] = 0; p_urgent[i] = 0;
            p_addr[i] = '0; p_wdata[i] = '0; p_mask[i] = '0;
            m_wait[i] = 0;
        end
        m_rr = 0; m_open_row = '0; m_row_valid = 0; m_tag_err = 0; m_rsp_valid = '0; m_rsp_data = '0;
        @(posedge clk);
        #1;
        step();
        chk_en = 1;

        // Reset held with every port valid and urgent: nothing may be granted.
        for (int p = 0; p < N; p++) begin
            raise(p, 1'b1, nxt_row);
            nxt_row     = nxt_row + 1'b1;
            p_urgent[p] = 1'b1;
        end
        step();
        check("rst_ready", obs_ready, 0);
        for (int p = 0; p < N; p++) p_urgent[p] = 1'b0;
        rst = 1'b0;

        // Plain round robin, every request on a fresh row.
        for (int k = 0; k < 5; k++) begin
            step();
            check("rr_seq", obs_ready, 64'(1) << (k % 4));
            if (last_g >= 0) begin
                raise(last_g, 1'b1, nxt_row);
                nxt_row = nxt_row + 1'b1;
            end
        end
        clear_all();

        // Open row 0x1234 with rr_ptr back at 0, then a row hit beats round robin.
        raise(3, 1'b1, 15'h1234);
        step();
        check("open_row_setup", obs_ready, 4'b1000);
        raise(0, 1'b1, 15'h0042);
        raise(2, 1'b1, 15'h1234);
        step();
        check("row_hit_grant", obs_ready, 4'b0100);
        check("row_hit_keep_open", obs_keep, 1'b1);
        clear_all();

        // Urgent beats row hit.
        raise(1, 1'b1, 15'h1234);
        p_urgent[1] = 1'b1;
        raise(3, 1'b1, 15'h1234);
        step();
        check("urgent_grant", obs_ready, 4'b0010);
        p_urgent[1] = 1'b0;

        // Port 0 misses the row while ports 1..3 keep hitting it: starvation takes over on cycle 65.
        raise(0, 1'b1, 15'h0777);
        for (int c = 1; c <= 65; c++) begin
            step();
            if (c < 65) check("starve_block", obs_ready[0], 1'b0);
            else        check("starve_grant", obs_ready, 4'b0001);
            for (int p = 1; p < N; p++) if (!p_valid[p]) raise(p, 1'b1, 15'h1234);
        end
        clear_all();

        // Fill the tag queue, then read blocked / write allowed until one return frees a slot.
        for (int j = 0; j < TQD; j++) begin
            raise(1, 1'b0, 15'h0100);
            step();
            check("fill_read", obs_ready, 4'b0010);
        end
        raise(0, 1'b0, 15'h0200);
        raise(2, 1'b1, 15'h0300);
        step();
        check("full_write_ok", obs_ready, 4'b0100);
        rd_valid = 1'b1;
        rd_data  = 16'h5A5A;
        step();
        check("full_read_block", obs_ready, 4'b0000);
        check("pop_rsp_valid", rsp_valid, 4'b0010);
        check("pop_rsp_data", rsp_data, 16'h5A5A);
        step();
        check("read_after_pop", obs_ready, 4'b0001);
        for (int j = 0; j < 40 && m_tagq.size() > 0; j++) begin
            rd_valid = 1'b1;
            rd_data  = DW'($urandom);
            step();
        end
        step();

        // In-order routing: reads from ports 3, 1, 3 return A, B, C.
        raise(3, 1'b0, pick_row());
        step();
        raise(1, 1'b0, pick_row());
        step();
        raise(3, 1'b0, pick_row());
        step();
        rd_valid = 1'b1; rd_data = 16'hA11A;
        step();
        check("route_a_valid", rsp_valid, 4'b1000);
        check("route_a_data", rsp_data, 16'hA11A);
        rd_valid = 1'b1; rd_data = 16'hB22B;
        step();
        check("route_b_valid", rsp_valid, 4'b0010);
        check("route_b_data", rsp_data, 16'hB22B);
        rd_valid = 1'b1; rd_data = 16'hC33C;
        step();
        check("route_c_valid", rsp_valid, 4'b1000);
        check("route_c_data", rsp_data, 16'hC33C);
        step();
        check("route_idle", rsp_valid, 4'b0000);

        // Command FIFO full blocks every grant.
        for (int p = 0; p < N; p++) raise(p, 1'b1, pick_row());
        cmd_full = 1'b1;
        for (int c = 0; c < 10; c++) begin
            step();
            check("cmd_full_block", obs_ready, 4'b0000);
        end
        cmd_full = 1'b0;
        clear_all();

        // Reset discards an outstanding read; the late return then flags tag_err.
        raise(2, 1'b0, pick_row());
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        rd_valid = 1'b1; rd_data = 16'hDEAD;
        step();
        check("tag_err_set", tag_err, 1'b1);
        check("tag_err_no_rsp", rsp_valid, 4'b0000);

        // Randomized traffic.
        rst = 1'b1;
        step();
        rst = 1'b0;
        for (int c = 0; c < 3000; c++) begin
            for (int p = 0; p < N; p++) begin
                if (!p_valid[p] && $urandom_range(0, 1) == 1)
                    raise(p, $urandom_range(0, 9) < 6, pick_row());
                p_urgent[p] = ($urandom_range(0, 9) == 0);
            end
            cmd_full = ($urandom_range(0, 6) == 0);
            rd_valid = (m_tagq.size() > 0) ? ($urandom_range(0, 9) < 4) : ($urandom_range(0, 199) == 0);
            rd_data  = DW'($urandom);
            rst      = ($urandom_range(0, 999) == 0);
            step();
        end
        rst = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
